// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_arbiter
// Brief    : Round-robin arbiter sharing the register-file write port between
//            ALU and load writebacks, with a pending-write hazard scoreboard.
// Revision : 1.0
// ============================================================================
module wb_port_arbiter #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [AW-1:0]        alu_rd,
  input  logic [XLEN-1:0]      alu_data,
  input  logic                 mem_valid,
  output logic                 mem_ready,
  input  logic [AW-1:0]        mem_rd,
  input  logic [XLEN-1:0]      mem_data,
  input  logic                 stall,
  output logic [AW-1:0]        wd,
  output logic [XLEN-1:0]      w_data,
  output logic                 w_enable,
  input  logic                 issue_valid,
  input  logic [AW-1:0]        issue_rd,
  input  logic [AW-1:0]        rs1,
  input  logic [AW-1:0]        rs2,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  output logic [(2**AW)-1:0]   busy_vec
);

  localparam int c_NREGS = 2**AW;

  typedef enum logic [0:0] {
    PRIO_ALU = 1'b0,
    PRIO_MEM = 1'b1
  } prio_t;

  prio_t               r_prio;
  logic                r_wen;
  logic [AW-1:0]       r_wd;
  logic [XLEN-1:0]     r_wdata;
  logic [c_NREGS-1:0]  r_busy;

  logic                w_commit;
  logic                w_slot_open;
  logic                w_grant_alu;
  logic                w_grant_mem;
  logic                w_acc_alu;
  logic                w_acc_mem;
  logic                w_accept;
  logic [AW-1:0]       w_acc_rd;
  logic [XLEN-1:0]     w_acc_data;
  logic [c_NREGS-1:0]  w_busy_next;

  assign w_commit    = r_wen & ~stall;
  // A committing slot can be refilled in the same cycle.
  assign w_slot_open = ~r_wen | ~stall;

  assign w_grant_alu = alu_valid & (~mem_valid | (r_prio == PRIO_ALU));
  assign w_grant_mem = mem_valid & (~alu_valid | (r_prio == PRIO_MEM));

  assign w_acc_alu   = w_grant_alu & w_slot_open;
  assign w_acc_mem   = w_grant_mem & w_slot_open;
  assign w_accept    = w_acc_alu | w_acc_mem;

  assign w_acc_rd    = w_acc_alu ? alu_rd   : mem_rd;
  assign w_acc_data  = w_acc_alu ? alu_data : mem_data;

  assign alu_ready   = w_acc_alu;
  assign mem_ready   = w_acc_mem;

  // Clear before set so an issue to the committing register keeps it busy.
  always_comb begin
    w_busy_next = r_busy;
    if (w_commit) begin
      w_busy_next[r_wd] = 1'b0;
    end
    if (issue_valid && (issue_rd != '0)) begin
      w_busy_next[issue_rd] = 1'b1;
    end
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prio  <= PRIO_ALU;
      r_wen   <= 1'b0;
      r_wd    <= '0;
      r_wdata <= '0;
      r_busy  <= '0;
    end else begin
      r_busy <= w_busy_next;
      if (w_accept) begin
        r_prio <= w_acc_alu ? PRIO_MEM : PRIO_ALU;
        // Writes to x0 are consumed but never reach the register file.
        if (w_acc_rd != '0) begin
          r_wen   <= 1'b1;
          r_wd    <= w_acc_rd;
          r_wdata <= w_acc_data;
        end else begin
          r_wen <= 1'b0;
        end
      end else if (w_commit) begin
        r_wen <= 1'b0;
      end
    end
  end

  assign wd       = r_wd;
  assign w_data   = r_wdata;
  assign w_enable = r_wen;
  assign busy_vec = r_busy;
  assign rs1_busy = r_busy[rs1];
  assign rs2_busy = r_busy[rs2];

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_port_arbiter
// Brief    : Scoreboard bench for wb_port_arbiter: directed scenarios plus
//            randomized traffic checked against a cycle-level reference model.
// Revision : 1.0
// ============================================================================
module tb_wb_port_arbiter;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NREG = 2**AW;

  logic            clk = 1'b0;
  logic            reset;
  logic            alu_valid, mem_valid, stall, issue_valid;
  logic            alu_ready, mem_ready, w_enable, rs1_busy, rs2_busy;
  logic [AW-1:0]   alu_rd, mem_rd, issue_rd, rs1, rs2, wd;
  logic [XLEN-1:0] alu_data, mem_data, w_data;
  logic [NREG-1:0] busy_vec;

  wb_port_arbiter #(.XLEN(XLEN), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .stall(stall), .wd(wd), .w_data(w_data), .w_enable(w_enable),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .rs1(rs1), .rs2(rs2),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: slot contents, last winner, and the set of pending registers.
  logic [AW+XLEN-1:0] exp_q[$];
  bit                 m_full;
  logic [AW-1:0]      m_rd;
  bit                 m_alu_turn;
  logic [NREG-1:0]    m_busy;
  bit                 m_commit, m_open, m_want_alu, m_want_mem, m_take_alu, m_take_mem;

  task automatic model_accept(input logic [AW-1:0] rd, input logic [XLEN-1:0] data);
    if (rd != 0) begin
      m_full = 1'b1;
      m_rd   = rd;
      exp_q.push_back({rd, data});
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      m_full     = 1'b0;
      m_rd       = '0;
      m_alu_turn = 1'b1;
      m_busy     = '0;
      exp_q.delete();
    end else begin
      check("busy_vec", busy_vec, m_busy);
      check("rs1_busy", rs1_busy, (rs1 != 0) && m_busy[rs1]);
      check("rs2_busy", rs2_busy, (rs2 != 0) && m_busy[rs2]);
      check("w_enable", w_enable, m_full);

      m_commit   = m_full && !stall;
      m_open     = !m_full || !stall;
      m_want_alu = alu_valid && (!mem_valid || m_alu_turn);
      m_want_mem = mem_valid && (!alu_valid || !m_alu_turn);
      m_take_alu = m_want_alu && m_open;
      m_take_mem = m_want_mem && m_open;
      check("alu_ready", alu_ready, m_take_alu);
      check("mem_ready", mem_ready, m_take_mem);

      if (issue_valid && issue_rd != 0 && m_busy[issue_rd] && !(m_commit && m_rd == issue_rd))
        check("waw_issue_illegal", 1, 0);

      if (m_commit) begin
        m_busy[m_rd] = 1'b0;
        m_full = 1'b0;
      end
      if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
      if (m_take_alu) begin
        model_accept(alu_rd, alu_data);
        m_alu_turn = 1'b0;
      end else if (m_take_mem) begin
        model_accept(mem_rd, mem_data);
        m_alu_turn = 1'b1;
      end
    end
  end

  // Monitor: every register-file write must match the oldest expected write.
  logic [AW+XLEN-1:0] mon_exp;
  always @(negedge clk) begin
    if (reset && w_enable && !stall) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {wd, w_data}, 0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("commit_write", {wd, w_data}, mon_exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_rd = '0; alu_data = '0;
    mem_valid = 0; mem_rd = '0; mem_data = '0;
    stall = 0; issue_valid = 0; issue_rd = '0; rs1 = '0; rs2 = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    reset = 1'b0;
    #3;
    check("reset_w_enable", w_enable, 0);
    check("reset_wd", wd, 0);
    check("reset_w_data", w_data, 0);
    check("reset_busy_vec", busy_vec, 0);
    step();
    reset = 1'b1;

    // Single ALU write
    issue_valid = 1; issue_rd = 5;
    step();
    issue_valid = 0; alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    @(negedge clk); check("single_alu_ready", alu_ready, 1);
    step();
    alu_valid = 0;
    @(negedge clk);
    check("single_w_enable", w_enable, 1);
    check("single_wd", wd, 5);
    check("single_w_data", w_data, 32'hDEADBEEF);
    check("single_busy5_pre", busy_vec[5], 1);
    step();
    @(negedge clk); check("single_busy5_post", busy_vec[5], 0);

    // Contention from reset: grants alternate ALU, MEM, ALU, MEM
    do_reset();
    alu_valid = 1; alu_rd = 1; alu_data = 32'h11;
    mem_valid = 1; mem_rd = 2; mem_data = 32'h22;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("contend_alu_ready", alu_ready, (i % 2) == 0);
      check("contend_mem_ready", mem_ready, (i % 2) == 1);
      step();
    end
    idle_inputs();
    step();

    // Stall hold
    do_reset();
    alu_valid = 1; alu_rd = 7; alu_data = 32'h1234;
    step();
    alu_valid = 0; stall = 1;
    mem_valid = 1; mem_rd = 8; mem_data = 32'h5678;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_wd", wd, 7);
      check("stall_w_data", w_data, 32'h1234);
      check("stall_mem_ready", mem_ready, 0);
      step();
    end
    stall = 0;
    @(negedge clk); check("stall_release_mem_ready", mem_ready, 1);
    step();
    mem_valid = 0;
    @(negedge clk);
    check("stall_next_wd", wd, 8);
    check("stall_next_w_data", w_data, 32'h5678);
    step();

    // x0 handling
    do_reset();
    alu_valid = 1; alu_rd = 0; alu_data = 32'hCAFE0000;
    issue_valid = 1; issue_rd = 0; rs1 = 0;
    @(negedge clk); check("x0_alu_ready", alu_ready, 1);
    step();
    idle_inputs();
    @(negedge clk);
    check("x0_w_enable", w_enable, 0);
    check("x0_busy_vec", busy_vec, 0);
    check("x0_rs1_busy", rs1_busy, 0);

    // Set/clear collision on x9
    do_reset();
    issue_valid = 1; issue_rd = 9;
    step();
    issue_valid = 0; alu_valid = 1; alu_rd = 9; alu_data = 32'h99;
    step();
    alu_valid = 0; issue_valid = 1; issue_rd = 9;
    @(negedge clk);
    check("collide_w_enable", w_enable, 1);
    check("collide_wd", wd, 9);
    step();
    issue_valid = 0;
    @(negedge clk); check("collide_busy9", busy_vec[9], 1);
    step();

    // Asynchronous reset with a pending slot and two busy registers
    do_reset();
    issue_valid = 1; issue_rd = 7;
    step();
    issue_rd = 9; alu_valid = 1; alu_rd = 3; alu_data = 32'hAA;
    step();
    issue_valid = 0; alu_valid = 0; stall = 1;
    #2;
    check("areset_pre_w_enable", w_enable, 1);
    check("areset_pre_busy_vec", busy_vec, 32'h0000_0280);
    reset = 1'b0;
    #1;
    check("areset_w_enable", w_enable, 0);
    check("areset_busy_vec", busy_vec, 0);
    check("areset_wd", wd, 0);
    step();
    step();
    idle_inputs();
    reset = 1'b1;
    alu_valid = 1; alu_rd = 4; alu_data = 32'h44;
    mem_valid = 1; mem_rd = 6; mem_data = 32'h66;
    @(negedge clk);
    check("areset_prio_alu", alu_ready, 1);
    step();
    idle_inputs();
    step();

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 600; c++) begin
      alu_valid   = ($urandom_range(0, 9) < 5);
      alu_rd      = AW'($urandom_range(0, NREG - 1));
      alu_data    = $urandom;
      mem_valid   = ($urandom_range(0, 9) < 5);
      mem_rd      = AW'($urandom_range(0, NREG - 1));
      mem_data    = $urandom;
      stall       = ($urandom_range(0, 9) < 3);
      rs1         = AW'($urandom_range(0, NREG - 1));
      rs2         = AW'($urandom_range(0, NREG - 1));
      issue_rd    = AW'($urandom_range(0, NREG - 1));
      issue_valid = ($urandom_range(0, 9) < 4) && !m_busy[issue_rd];
      step();
    end
    idle_inputs();
    repeat (4) step();
    check("drain_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
